mem_port_arbiter: RTL and testbench

- Shares one slow line-wide memory port between the read-only instruction cache and the read/write data cache.
- Sits between both cache mem-side interfaces and the external memory.
- Registers the request toward memory and the response toward the caches.
- Guarantees exactly one outstanding line transaction at a time.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-client line arbiter for a single slow memory port; one outstanding transaction at a time.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN selects round-robin grant instead of fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,

  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,

  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,

  output logic              owner
);

  // state | meaning
  // IDLE  | no transaction; sample client requests and grant one
  // BUSY  | request held toward memory, waiting for mem_ready
  // RESP  | ready pulse to owner; stale client requests ignored
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state, state_n;
  logic                mem_read_n, mem_write_n, owner_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [LINE_W-1:0]   mem_wdata_n, i_rdata_n, d_rdata_n;
  logic                i_ready_n, d_ready_n;
  logic                req_i, req_d, grant_d;
  logic                unused_i_write;

  // The I-cache is read-only; its write strobe is deliberately dropped.
  assign unused_i_write = i_mem_write;

  assign req_i = i_mem_read;
  assign req_d = d_mem_read | d_mem_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On contention the client that was not served last wins.
  assign grant_d = req_d & (~req_i | ~owner);
`else
  assign grant_d = req_d;
`endif

  always_ff @(posedge clk) begin
    if (proc_reset) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n     = state;
    mem_read_n  = mem_read;
    mem_write_n = mem_write;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    owner_n     = owner;
    i_rdata_n   = i_mem_rdata;
    d_rdata_n   = d_mem_rdata;
    i_ready_n   = 1'b0;
    d_ready_n   = 1'b0;

    case (state)
      IDLE: begin
        if (req_i | req_d) begin
          state_n = BUSY;
          owner_n = grant_d;
          if (grant_d) begin
            // A pending write-back goes out before a D read.
            mem_addr_n  = d_mem_addr;
            mem_wdata_n = d_mem_wdata;
            mem_write_n = d_mem_write;
            mem_read_n  = ~d_mem_write;
          end else begin
            mem_addr_n  = i_mem_addr;
            mem_write_n = 1'b0;
            mem_read_n  = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_n     = RESP;
          mem_read_n  = 1'b0;
          mem_write_n = 1'b0;
          if (owner) begin
            d_rdata_n = mem_rdata;
            d_ready_n = 1'b1;
          end else begin
            i_rdata_n = mem_rdata;
            i_ready_n = 1'b1;
          end
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      owner       <= 1'b1;
      i_mem_rdata <= '0;
      d_mem_rdata <= '0;
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
    end else begin
      mem_read    <= mem_read_n;
      mem_write   <= mem_write_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      owner       <= owner_n;
      i_mem_rdata <= i_rdata_n;
      d_mem_rdata <= d_rdata_n;
      i_mem_ready <= i_ready_n;
      d_mem_ready <= d_ready_n;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a grant-order model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              proc_reset;
  logic              i_mem_read, i_mem_write;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_ready;
  logic              d_mem_read, d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [LINE_W-1:0] d_mem_wdata, d_mem_rdata;
  logic              d_mem_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;
  logic              owner;

  int vectors = 0;
  int errors  = 0;

  localparam logic [LINE_W-1:0] DATA_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] DATA_12 = {8{16'h1234}};

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .owner(owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_addr = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  // Memory answers lat edges after the grant was observed.
  task automatic mem_respond(input int lat, input logic [LINE_W-1:0] data);
    for (int k = 1; k < lat; k++) tick();
    mem_ready = 1'b1; mem_rdata = data;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic wait_grant(input int budget, output int cycles, output bit ok);
    cycles = 0; ok = 1'b0;
    while (cycles < budget && !ok) begin
      tick();
      cycles++;
      if (mem_read === 1'b1 || mem_write === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    proc_reset = 1'b1; idle_inputs();
    tick(); tick();
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {mem_read, mem_write, i_mem_ready, d_mem_ready});
    vectors++;
    if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner: got %b expected 1", owner); end
    vectors++;
    if (mem_addr !== '0 || mem_wdata !== '0 || i_mem_rdata !== '0 || d_mem_rdata !== '0) begin
      errors++; $display("FAIL reset_data: addr %h wdata %h ird %h drd %h expected all 0", mem_addr, mem_wdata, i_mem_rdata, d_mem_rdata);
    end
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000) errors++;
    proc_reset = 1'b0;
    tick();
  endtask

  task automatic test_single_i_read();
    i_mem_addr = 28'h0000010; i_mem_read = 1'b1; i_mem_write = 1'b1;
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h0000010) begin
      errors++; $display("FAIL i_grant: rd/wr %b addr %h expected 10 0000010", {mem_read, mem_write}, mem_addr);
    end
    mem_respond(4, DATA_A5);
    vectors++;
    if (i_mem_ready !== 1'b1 || d_mem_ready !== 1'b0 || i_mem_rdata !== DATA_A5 || owner !== 1'b0) begin
      errors++; $display("FAIL i_resp: irdy %b drdy %b rdata %h owner %b expected 1 0 %h 0", i_mem_ready, d_mem_ready, i_mem_rdata, owner, DATA_A5);
    end
    i_mem_read = 1'b0; i_mem_write = 1'b0;
    tick();
    vectors++;
    if (i_mem_ready !== 1'b0 || mem_read !== 1'b0) begin
      errors++; $display("FAIL i_pulse_width: irdy %b mem_read %b expected 0 0", i_mem_ready, mem_read);
    end
    tick();
  endtask

  task automatic test_d_write();
    d_mem_addr = 28'h0000200; d_mem_wdata = DATA_12; d_mem_write = 1'b1;
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b01 || mem_addr !== 28'h0000200 || mem_wdata !== DATA_12 || owner !== 1'b1) begin
      errors++; $display("FAIL d_wr_grant: rd/wr %b addr %h wdata %h owner %b", {mem_read, mem_write}, mem_addr, mem_wdata, owner);
    end
    mem_respond(3, {4{32'hDEADBEEF}});
    vectors++;
    if (d_mem_ready !== 1'b1 || i_mem_ready !== 1'b0 || i_mem_rdata !== DATA_A5) begin
      errors++; $display("FAIL d_wr_resp: drdy %b irdy %b ird %h expected 1 0 %h", d_mem_ready, i_mem_ready, i_mem_rdata, DATA_A5);
    end
    d_mem_write = 1'b0;
    tick();
    vectors++;
    if (d_mem_ready !== 1'b0) begin errors++; $display("FAIL d_wr_pulse: drdy %b expected 0", d_mem_ready); end
    tick();
  endtask

  task automatic test_d_write_read();
    d_mem_addr = 28'h0000300; d_mem_wdata = {4{32'h0BADF00D}};
    d_mem_write = 1'b1; d_mem_read = 1'b1;
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b01) begin errors++; $display("FAIL dwr_first: rd/wr %b expected 01", {mem_read, mem_write}); end
    mem_respond(2, '0);
    d_mem_write = 1'b0;
    tick();
    vectors++;
    if ({mem_read, mem_write, d_mem_ready} !== 3'b000) begin
      errors++; $display("FAIL dwr_resp_gap: rd/wr/rdy %b expected 000", {mem_read, mem_write, d_mem_ready});
    end
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h0000300) begin
      errors++; $display("FAIL dwr_second: rd/wr %b addr %h expected 10 0000300", {mem_read, mem_write}, mem_addr);
    end
    mem_respond(2, {4{32'hCAFE0001}});
    vectors++;
    if (d_mem_ready !== 1'b1 || d_mem_rdata !== {4{32'hCAFE0001}}) begin
      errors++; $display("FAIL dwr_rdata: drdy %b rdata %h", d_mem_ready, d_mem_rdata);
    end
    d_mem_read = 1'b0;
    tick(); tick();
  endtask

  task automatic test_both_same_cycle();
    bit first_d;
    first_d = !RR;  // owner is 1 here, so round-robin favours I
    i_mem_addr = 28'h0000500; d_mem_addr = 28'h0000400;
    i_mem_read = 1'b1; d_mem_read = 1'b1;
    tick();
    vectors++;
    if (owner !== first_d || mem_addr !== (first_d ? 28'h0000400 : 28'h0000500) || mem_read !== 1'b1) begin
      errors++; $display("FAIL both_first: owner %b addr %h expected %b", owner, mem_addr, first_d);
    end
    mem_respond(3, {4{32'h11112222}});
    vectors++;
    if ({i_mem_ready, d_mem_ready} !== {!first_d, first_d}) begin
      errors++; $display("FAIL both_first_rdy: got %b expected %b", {i_mem_ready, d_mem_ready}, {!first_d, first_d});
    end
    if (first_d) d_mem_read = 1'b0; else i_mem_read = 1'b0;
    tick();
    vectors++;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL both_gap: mem_read %b expected 0", mem_read); end
    tick();
    vectors++;
    if (owner !== !first_d || mem_read !== 1'b1 || mem_addr !== (first_d ? 28'h0000500 : 28'h0000400)) begin
      errors++; $display("FAIL both_second: owner %b rd %b addr %h", owner, mem_read, mem_addr);
    end
    mem_respond(1, {4{32'h33334444}});
    vectors++;
    if ({i_mem_ready, d_mem_ready} !== {first_d, !first_d}) begin
      errors++; $display("FAIL both_second_rdy: got %b expected %b", {i_mem_ready, d_mem_ready}, {first_d, !first_d});
    end
    i_mem_read = 1'b0; d_mem_read = 1'b0;
    tick(); tick();
  endtask

  task automatic test_held_request();
    i_mem_addr = 28'h0000777; i_mem_read = 1'b1;
    tick();
    mem_respond(2, {4{32'h5555AAAA}});
    tick();  // request still high through the ready cycle
    vectors++;
    if ({mem_read, mem_write, i_mem_ready} !== 3'b000) begin
      errors++; $display("FAIL held_resp: rd/wr/irdy %b expected 000", {mem_read, mem_write, i_mem_ready});
    end
    i_mem_read = 1'b0;
    tick();
    vectors++;
    if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL held_dup: rd/wr %b expected 00", {mem_read, mem_write}); end
    d_mem_addr = 28'h0000888; d_mem_read = 1'b1;
    tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000888 || owner !== 1'b1) begin
      errors++; $display("FAIL held_next: rd %b addr %h owner %b expected 1 0000888 1", mem_read, mem_addr, owner);
    end
    mem_respond(1, '0);
    d_mem_read = 1'b0;
    tick(); tick();
  endtask

  task automatic test_mid_reset();
    i_mem_addr = 28'h0000123; i_mem_read = 1'b1;
    tick();
    tick(); tick();
    proc_reset = 1'b1; i_mem_read = 1'b0;
    tick();
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000 || owner !== 1'b1) begin
      errors++; $display("FAIL rst_mid: rd/wr/irdy/drdy %b owner %b expected 0000 1", {mem_read, mem_write, i_mem_ready, d_mem_ready}, owner);
    end
    proc_reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = {4{32'hFFFF0000}};
    tick();
    mem_ready = 1'b0;
    tick();
    vectors++;
    if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000 || i_mem_rdata !== '0 || d_mem_rdata !== '0) begin
      errors++; $display("FAIL rst_discard: ctrl %b ird %h drd %h expected 0000 0 0", {mem_read, mem_write, i_mem_ready, d_mem_ready}, i_mem_rdata, d_mem_rdata);
    end
    d_mem_addr = 28'h0000999; d_mem_read = 1'b1;
    tick();
    vectors++;
    if (mem_read !== 1'b1 || mem_addr !== 28'h0000999) begin
      errors++; $display("FAIL rst_idle: rd %b addr %h expected 1 0000999", mem_read, mem_addr);
    end
    mem_respond(2, '0);
    d_mem_read = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] ia, da, exp_addr;
    logic [LINE_W-1:0] dwd, rd, m_irdata, m_drdata;
    bit pi, pdw, pdr, m_owner, exp_d, exp_wr, ok;
    int cyc, lat;
    proc_reset = 1'b1; idle_inputs();
    tick();
    proc_reset = 1'b0;
    tick();
    m_owner = 1'b1; m_irdata = '0; m_drdata = '0;
    for (int it = 0; it < 60; it++) begin
      pi = 1'($urandom); pdw = 1'($urandom); pdr = 1'($urandom);
      ia = ADDR_W'($urandom); da = ADDR_W'($urandom);
      dwd = {$urandom, $urandom, $urandom, $urandom};
      i_mem_addr = ia; d_mem_addr = da; d_mem_wdata = dwd;
      i_mem_write = 1'($urandom);
      i_mem_read = pi; d_mem_write = pdw; d_mem_read = pdr;
      if (!(pi | pdw | pdr)) begin
        mem_ready = 1'b1; mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        tick();
        mem_ready = 1'b0;
        tick();
        vectors++;
        if ({mem_read, mem_write, i_mem_ready, d_mem_ready} !== 4'b0000 || i_mem_rdata !== m_irdata || d_mem_rdata !== m_drdata) begin
          errors++; $display("FAIL rnd_idle: ctrl %b expected 0000 with rdata unchanged", {mem_read, mem_write, i_mem_ready, d_mem_ready});
        end
      end
      while (pi | pdw | pdr) begin
        if ((pdw | pdr) && pi) exp_d = RR ? !m_owner : 1'b1;
        else                   exp_d = pdw | pdr;
        exp_wr   = exp_d & pdw;
        exp_addr = exp_d ? da : ia;
        wait_grant(8, cyc, ok);
        vectors++;
        if (!ok || cyc != 1) begin
          errors++; $display("FAIL rnd_grant_lat: got %0d cycles (ok %b) expected 1", cyc, ok);
          idle_inputs(); proc_reset = 1'b1; tick(); proc_reset = 1'b0; tick();
          pi = 1'b0; pdw = 1'b0; pdr = 1'b0;
          m_owner = 1'b1; m_irdata = '0; m_drdata = '0;
          continue;
        end
        vectors++;
        if ({mem_read, mem_write} !== {!exp_wr, exp_wr} || mem_addr !== exp_addr || owner !== exp_d ||
            (exp_wr && mem_wdata !== dwd)) begin
          errors++; $display("FAIL rnd_grant: rd/wr %b addr %h owner %b expected %b %h %b",
                             {mem_read, mem_write}, mem_addr, owner, {!exp_wr, exp_wr}, exp_addr, exp_d);
        end
        lat = $urandom_range(1, 6);
        rd  = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 1; k < lat; k++) begin
          tick();
          vectors++;
          if ({mem_read, mem_write} !== {!exp_wr, exp_wr} || mem_addr !== exp_addr || i_mem_ready !== 1'b0 || d_mem_ready !== 1'b0) begin
            errors++; $display("FAIL rnd_hold: rd/wr %b addr %h rdy %b expected %b %h 00",
                               {mem_read, mem_write}, mem_addr, {i_mem_ready, d_mem_ready}, {!exp_wr, exp_wr}, exp_addr);
          end
        end
        mem_ready = 1'b1; mem_rdata = rd;
        tick();
        mem_ready = 1'b0;
        if (exp_d) m_drdata = rd; else m_irdata = rd;
        m_owner = exp_d;
        vectors++;
        if ({i_mem_ready, d_mem_ready} !== {!exp_d, exp_d} || {mem_read, mem_write} !== 2'b00) begin
          errors++; $display("FAIL rnd_ready: rdy %b rd/wr %b expected %b 00", {i_mem_ready, d_mem_ready}, {mem_read, mem_write}, {!exp_d, exp_d});
        end
        vectors++;
        if (i_mem_rdata !== m_irdata || d_mem_rdata !== m_drdata) begin
          errors++; $display("FAIL rnd_rdata: ird %h drd %h expected %h %h", i_mem_rdata, d_mem_rdata, m_irdata, m_drdata);
        end
        if (!exp_d)     begin pi  = 1'b0; i_mem_read  = 1'b0; end
        else if (exp_wr) begin pdw = 1'b0; d_mem_write = 1'b0; end
        else            begin pdr = 1'b0; d_mem_read  = 1'b0; end
        tick();
        vectors++;
        if ({i_mem_ready, d_mem_ready, mem_read, mem_write} !== 4'b0000) begin
          errors++; $display("FAIL rnd_resp_end: rdy/rd/wr %b expected 0000", {i_mem_ready, d_mem_ready, mem_read, mem_write});
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_i_read();
    test_d_write();
    test_d_write_read();
    test_both_same_cycle();
    test_held_request();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
